// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// ALU codes, opcode/funct values, mux selects and the packed control bundle.
package mc_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_OR  = 5'd2;
    localparam logic [4:0] ALU_LUI = 5'd3;
    localparam logic [4:0] ALU_SLL = 5'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    localparam logic [1:0] ASA_PC     = 2'd0;
    localparam logic [1:0] ASA_RDATA1 = 2'd1;
    localparam logic [1:0] ASA_SHAMT  = 2'd2;
    localparam logic [1:0] ASB_RDATA2 = 2'd0;
    localparam logic [1:0] ASB_FOUR   = 2'd1;
    localparam logic [1:0] ASB_IMM    = 2'd2;
    localparam logic [1:0] ASB_IMMSH2 = 2'd3;
    localparam logic [1:0] RD_RT      = 2'd0;
    localparam logic [1:0] RD_RD      = 2'd1;
    localparam logic [1:0] RD_RA      = 2'd2;
    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;
    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RDATA1 = 2'd3;
    localparam logic [1:0] EXT_ZERO   = 2'd0;
    localparam logic [1:0] EXT_SIGN   = 2'd1;
    localparam logic [1:0] EXT_UPPER  = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [4:0] alu_ctrl;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_src;
        logic [1:0] ext_op;
    } ctrl_t;

    // Unrecognised encodings fall back to FETCH and retire as a NOP.
    function automatic logic [3:0] decode_next(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] nxt;
        nxt = S_FETCH;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU, FN_SLL: nxt = S_EXEC_R;
                    FN_JR:                    nxt = S_JUMP;
                    default:                  nxt = S_FETCH;
                endcase
            end
            OP_ORI, OP_LUI: nxt = S_EXEC_I;
            OP_LW, OP_SW:   nxt = S_MEM_ADDR;
            OP_BEQ:         nxt = S_BRANCH;
            OP_J, OP_JAL:   nxt = S_JUMP;
            default:        nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_controller_decode.sv
// Moore output decode: maps (state, latched opcode/funct) to datapath controls.
// Only BRANCH looks at a live input (zero) to qualify its PC write.
module mc_decode
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op_q,
    input  logic [5:0] funct_q,
    input  logic       zero,
    output ctrl_t      ctrl
);

    logic is_rtype_s;
    assign is_rtype_s = (op_q == OP_RTYPE);

    // Per-state control decode; every field not driven below stays zero.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_a = ASA_PC;
                ctrl.alu_src_b = ASB_FOUR;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.pc_src    = PCS_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_a = ASA_PC;
                ctrl.alu_src_b = ASB_IMMSH2;
                ctrl.ext_op    = EXT_SIGN;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = (funct_q == FN_SLL) ? ASA_SHAMT : ASA_RDATA1;
                ctrl.alu_src_b = ASB_RDATA2;
                if (funct_q == FN_SLL) begin
                    ctrl.alu_ctrl = ALU_SLL;
                end else if (funct_q == FN_SUBU) begin
                    ctrl.alu_ctrl = ALU_SUB;
                end else begin
                    ctrl.alu_ctrl = ALU_ADD;
                end
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = ASA_RDATA1;
                ctrl.alu_src_b = ASB_IMM;
                ctrl.ext_op    = (op_q == OP_LUI) ? EXT_UPPER : EXT_ZERO;
                ctrl.alu_ctrl  = (op_q == OP_LUI) ? ALU_LUI : ALU_OR;
            end
            S_WB_ALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = is_rtype_s ? RD_RD : RD_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = ASA_RDATA1;
                ctrl.alu_src_b = ASB_IMM;
                ctrl.ext_op    = EXT_SIGN;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            S_MEM_RD: ctrl.mem_read  = 1'b1;
            S_MEM_WR: ctrl.mem_write = 1'b1;
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = RD_RT;
                ctrl.mem_to_reg = M2R_MDR;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = ASA_RDATA1;
                ctrl.alu_src_b = ASB_RDATA2;
                ctrl.alu_ctrl  = ALU_SUB;
                ctrl.pc_src    = PCS_ALUOUT;
                ctrl.pc_write  = zero;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = (is_rtype_s && funct_q == FN_JR) ? PCS_RDATA1 : PCS_JUMP;
                if (op_q == OP_JAL) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_RA;
                    ctrl.mem_to_reg = M2R_PC;
                end else begin
                    ctrl.reg_write  = 1'b0;
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller top: state register, instruction-field latches and the
// retired-instruction counter; output decode lives in mc_decode.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [4:0]  alu_ctrl,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  pc_src,
    output logic [1:0]  ext_op,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    logic [3:0]  state_r;
    logic [3:0]  next_state_s;
    logic [5:0]  op_q;
    logic [5:0]  funct_q;
    logic [31:0] retired_r;
    logic        retire_s;
    ctrl_t       ctrl_s;

    // Next-state selection; memory states hold until the data memory reports done.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:            next_state_s = S_DECODE;
            S_DECODE:           next_state_s = decode_next(op_q, funct_q);
            S_EXEC_R, S_EXEC_I: next_state_s = S_WB_ALU;
            S_MEM_ADDR:         next_state_s = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:           next_state_s = dmem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:           next_state_s = dmem_ready ? S_FETCH : S_MEM_WR;
            default:            next_state_s = S_FETCH;
        endcase
    end

    assign retire_s = (state_r != S_FETCH) && (next_state_s == S_FETCH);

    // State, instruction-field latches (captured leaving FETCH) and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_FETCH;
            op_q      <= 6'd0;
            funct_q   <= 6'd0;
            retired_r <= 32'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == S_FETCH) begin
                op_q    <= opcode;
                funct_q <= funct;
            end
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    mc_decode u_decode (
        .state   (state_r),
        .op_q    (op_q),
        .funct_q (funct_q),
        .zero    (zero),
        .ctrl    (ctrl_s)
    );

    assign pc_write   = ctrl_s.pc_write;
    assign ir_write   = ctrl_s.ir_write;
    assign reg_write  = ctrl_s.reg_write;
    assign mem_read   = ctrl_s.mem_read;
    assign mem_write  = ctrl_s.mem_write;
    assign alu_src_a  = ctrl_s.alu_src_a;
    assign alu_src_b  = ctrl_s.alu_src_b;
    assign alu_ctrl   = ctrl_s.alu_ctrl;
    assign reg_dst    = ctrl_s.reg_dst;
    assign mem_to_reg = ctrl_s.mem_to_reg;
    assign pc_src     = ctrl_s.pc_src;
    assign ext_op     = ctrl_s.ext_op;
    assign state      = state_r;
    assign retired    = retired_r;

endmodule
